dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: data memory depth in 32-bit words.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-004 SHALL have ports r0_req_valid / r1_req_valid  input  1: requester 0 (core LSU) / requester 1 (loader/DMA) request valid.
REQ-005 SHALL have ports rN_req_ready  output  1: request accepted when rN_req_valid and rN_req_ready are both high on a rising edge.
REQ-006 SHALL have ports rN_req_addr  input  32: byte address.
REQ-007 SHALL have ports rN_req_wdata  input  32: store data.
REQ-008 SHALL have ports rN_req_mask  input  3: funct3 access size (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 SHALL have ports rN_req_we  input  1: 1 = store, 0 = load.
REQ-010 SHALL have ports rN_rsp_valid  output  1: one-cycle response pulse; no back-pressure.
REQ-011 SHALL have ports rN_rsp_rdata  output  32: load result, 0 for stores and errors.
REQ-012 SHALL have ports rN_rsp_err  output  1: access rejected.
REQ-013 SHALL have ports mem_addr / mem_wdata  output  32: data memory address / write data.
REQ-014 SHALL have port mem_mask  output  3: data memory access size.
REQ-015 SHALL have ports mem_wr_en / mem_rd_en  output  1: data memory enables.
REQ-016 SHALL have port mem_rdata  input  32: combinational memory read data.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> RESP, with RESP -> ACCESS on a same-cycle accept and RESP -> IDLE otherwise.
REQ-018 SHALL assert rN_req_ready only in IDLE or RESP, and only for the requester granted that cycle.
REQ-019 SHALL arbitrate round-robin: a sole valid requester wins; if both are valid, the requester not granted last wins; the last-grant pointer updates only on accept.
REQ-020 SHALL register addr, wdata, mask, we and requester id into a command register on accept, with the FSM in ACCESS the next cycle.
REQ-021 SHALL drive mem_* from the command register in ACCESS only; mem_rd_en = !we and mem_wr_en = we, with both 0 in all other states.
REQ-022 SHALL capture mem_rdata at the end of ACCESS and raise rsp_valid on the owning requester in RESP, giving accept-to-rsp_valid latency of 2 cycles and 1 transaction per 2 cycles sustained.
REQ-023 SHALL flag as error: word address >= MEM_WORDS; H/HU with addr[0]=1; W with addr[1:0]!=0; masks 011/110/111; stores with mask[2]=1.
REQ-024 SHALL keep both mem enables low in ACCESS for an erroring command, and respond with rsp_err=1 and rsp_rdata=0.
REQ-025 SHALL return rsp_rdata=0 and rsp_err=0 for a successful store.
REQ-026 SHALL leave the non-owning requester's rsp_valid at 0 and its rsp_rdata and rsp_err at 0.
REQ-027 SHALL gate mem_wr_en and mem_rd_en with !rst, so that no write occurs in a cycle where rst is high.

Reset
REQ-028 SHALL, on rst, enter IDLE, set the last-grant pointer to 1 (so requester 0 wins the first tie), and clear the command register.
REQ-029 SHALL hold all rsp_valid, rsp_err, rsp_rdata, mem_* and req_ready outputs at 0 while rst is high.
REQ-030 SHALL drop an in-flight transaction on reset mid-operation with no response.

Structure
REQ-031 SHALL place the FSM state enum, mask encoding constants and the command struct in shared package dmem_pkg.
REQ-032 SHALL implement arbitration in sub-module rr_arbiter2 (valid[1:0], accept, pointer -> grant[1:0]).

Verification
REQ-033 SHALL cover a single load: memory word 0x10 = 0xDEADBEEF; r0 LB at addr 0x43 -> r0_rsp_valid 2 cycles after accept with rdata 0xFFFFFFDE, err 0.
REQ-034 SHALL cover a tie: r0 and r1 both valid from reset -> r0 granted first, r1 next; with both continuously valid, grants alternate 0,1,0,1 at 2-cycle spacing.
REQ-035 SHALL cover misaligned access: r1 SW at addr 0x06 -> no mem_wr_en pulse; r1_rsp_err=1, rdata=0.
REQ-036 SHALL cover the range limit: with MEM_WORDS=1024, r0 LW at addr 0x1000 -> err=1; LW at 0xFFC -> err=0.
REQ-037 SHALL cover reset during a write: rst high in the ACCESS cycle of r0 SW -> mem_wr_en stays 0, the word is unchanged, no rsp_valid, and the FSM is in IDLE.
REQ-038 SHALL cover back-to-back requests: r0 SB 0xAB at addr 0x1 accepted in RESP of the previous transaction -> mem_wr_en 1 cycle later with mem_mask 000.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states, access-size
// encodings, the command register layout, and access checking/load extraction.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mask;
    logic        we;
    logic        id;
    logic        err;
  } cmd_t;

  // Out-of-range word, misaligned half/word, reserved size, or unsigned-size store.
  function automatic logic access_err(input logic [31:0] addr, input logic [2:0] mask,
                                      input logic we, input logic [31:0] words);
    logic err;
    err = 1'b0;
    if ({2'b00, addr[31:2]} >= words) err = 1'b1;
    case (mask)
      MASK_B, MASK_BU: err = err;
      MASK_H, MASK_HU: if (addr[0]) err = 1'b1;
      MASK_W:          if (addr[1:0] != 2'b00) err = 1'b1;
      default:         err = 1'b1;
    endcase
    if (we && mask[2]) err = 1'b1;
    return err;
  endfunction

  // Memory returns the full aligned word; select the lane and extend it here.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lo,
                                               input logic [2:0] mask);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (mask)
      MASK_B:  r = {{24{b[7]}}, b};
      MASK_BU: r = {24'h000000, b};
      MASK_H:  r = {{16{h[15]}}, h};
      MASK_HU: r = {16'h0000, h};
      MASK_W:  r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant pointer advances only on accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic pointer_r;

  always_comb begin
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pointer_r ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pointer_r <= 1'b1;
    end else if (accept) begin
      pointer_r <= grant[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: one command in flight, IDLE/ACCESS/RESP FSM,
// access checking and load-lane extraction, responses routed to the owner.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req_valid,
  output logic        r0_req_ready,
  input  logic [31:0] r0_req_addr,
  input  logic [31:0] r0_req_wdata,
  input  logic [2:0]  r0_req_mask,
  input  logic        r0_req_we,
  output logic        r0_rsp_valid,
  output logic [31:0] r0_rsp_rdata,
  output logic        r0_rsp_err,
  input  logic        r1_req_valid,
  output logic        r1_req_ready,
  input  logic [31:0] r1_req_addr,
  input  logic [31:0] r1_req_wdata,
  input  logic [2:0]  r1_req_mask,
  input  logic        r1_req_we,
  output logic        r1_rsp_valid,
  output logic [31:0] r1_rsp_rdata,
  output logic        r1_rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata
);

  state_t      state_r;
  cmd_t        cmd_r;
  cmd_t        next_cmd;
  logic [1:0]  grant;
  logic        can_accept;
  logic        accept;
  logic        in_access;
  logic [31:0] load_data;
  logic [1:0]  rsp_valid_r;
  logic [1:0]  rsp_err_r;
  logic [31:0] rsp_rdata0_r;
  logic [31:0] rsp_rdata1_r;

  assign can_accept = ((state_r == ST_IDLE) || (state_r == ST_RESP)) && !rst;
  assign accept     = can_accept && (r0_req_valid || r1_req_valid);
  assign in_access  = (state_r == ST_ACCESS) && !rst;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({r1_req_valid, r0_req_valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign r0_req_ready = can_accept && grant[0];
  assign r1_req_ready = can_accept && grant[1];

  always_comb begin
    next_cmd = '0;
    if (grant[1]) begin
      next_cmd.addr  = r1_req_addr;
      next_cmd.wdata = r1_req_wdata;
      next_cmd.mask  = r1_req_mask;
      next_cmd.we    = r1_req_we;
      next_cmd.id    = 1'b1;
    end else begin
      next_cmd.addr  = r0_req_addr;
      next_cmd.wdata = r0_req_wdata;
      next_cmd.mask  = r0_req_mask;
      next_cmd.we    = r0_req_we;
      next_cmd.id    = 1'b0;
    end
    next_cmd.err = access_err(next_cmd.addr, next_cmd.mask, next_cmd.we, 32'(MEM_WORDS));
  end

  // Memory port is live only in ACCESS; a rejected command never touches memory.
  always_comb begin
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    mem_mask  = 3'b000;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    if (in_access) begin
      mem_addr  = cmd_r.addr;
      mem_wdata = cmd_r.wdata;
      mem_mask  = cmd_r.mask;
      mem_wr_en = cmd_r.we && !cmd_r.err;
      mem_rd_en = !cmd_r.we && !cmd_r.err;
    end else begin
      mem_wr_en = 1'b0;
      mem_rd_en = 1'b0;
    end
  end

  assign load_data = (cmd_r.err || cmd_r.we) ? 32'h0000_0000
                   : load_extract(mem_rdata, cmd_r.addr[1:0], cmd_r.mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cmd_r        <= '0;
      rsp_valid_r  <= 2'b00;
      rsp_err_r    <= 2'b00;
      rsp_rdata0_r <= 32'h0000_0000;
      rsp_rdata1_r <= 32'h0000_0000;
    end else begin
      rsp_valid_r  <= 2'b00;
      rsp_err_r    <= 2'b00;
      rsp_rdata0_r <= 32'h0000_0000;
      rsp_rdata1_r <= 32'h0000_0000;
      case (state_r)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            cmd_r   <= next_cmd;
            state_r <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state_r                <= ST_RESP;
          rsp_valid_r[cmd_r.id]  <= 1'b1;
          rsp_err_r[cmd_r.id]    <= cmd_r.err;
          if (cmd_r.id) begin
            rsp_rdata1_r <= load_data;
          end else begin
            rsp_rdata0_r <= load_data;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign r0_rsp_valid = rsp_valid_r[0] && !rst;
  assign r1_rsp_valid = rsp_valid_r[1] && !rst;
  assign r0_rsp_err   = rsp_err_r[0] && !rst;
  assign r1_rsp_err   = rsp_err_r[1] && !rst;
  assign r0_rsp_rdata = rst ? 32'h0000_0000 : rsp_rdata0_r;
  assign r1_rsp_rdata = rst ? 32'h0000_0000 : rsp_rdata1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a transaction table plus hand-written
// sequences for reset, round-robin ties, back-to-back accept and reset mid-write.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        r0_req_valid, r1_req_valid;
  logic        r0_req_ready, r1_req_ready;
  logic [31:0] r0_req_addr, r1_req_addr, r0_req_wdata, r1_req_wdata;
  logic [2:0]  r0_req_mask, r1_req_mask;
  logic        r0_req_we, r1_req_we;
  logic        r0_rsp_valid, r1_rsp_valid;
  logic [31:0] r0_rsp_rdata, r1_rsp_rdata;
  logic        r0_rsp_err, r1_rsp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_mask;
  logic        mem_wr_en, mem_rd_en;

  logic [31:0] mem [0:1023];
  logic [31:0] wtmp;
  int          n_total = 0;
  int          n_pass  = 0;

  dmem_arbiter #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_addr(r0_req_addr),
    .r0_req_wdata(r0_req_wdata), .r0_req_mask(r0_req_mask), .r0_req_we(r0_req_we),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata), .r0_rsp_err(r0_rsp_err),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_addr(r1_req_addr),
    .r1_req_wdata(r1_req_wdata), .r1_req_mask(r1_req_mask), .r1_req_we(r1_req_we),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata), .r1_rsp_err(r1_rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational word read, byte-lane writes by access size.
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_wr_en) begin
      wtmp = mem[mem_addr[11:2]];
      case (mem_mask[1:0])
        2'b00:   wtmp[mem_addr[1:0]*8 +: 8] = mem_wdata[7:0];
        2'b01:   wtmp[mem_addr[1]*16 +: 16] = mem_wdata[15:0];
        default: wtmp = mem_wdata;
      endcase
      mem[mem_addr[11:2]] <= wtmp;
    end
  end

  typedef struct {
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic id, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] mask,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.id = id; v.we = we; v.addr = addr; v.wdata = wdata; v.mask = mask;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic id, input logic valid, input vec_t v);
    if (id) begin
      r1_req_valid = valid; r1_req_addr = v.addr; r1_req_wdata = v.wdata;
      r1_req_mask = v.mask; r1_req_we = v.we;
    end else begin
      r0_req_valid = valid; r0_req_addr = v.addr; r0_req_wdata = v.wdata;
      r0_req_mask = v.mask; r0_req_we = v.we;
    end
  endtask

  // One complete transaction: wait for ready, accept, check memory strobes in
  // ACCESS and the response exactly two cycles after the accepting edge.
  task automatic run_vec(input string tag, input vec_t v);
    logic rdy;
    int   waited;
    @(negedge clk);
    drive(v.id, 1'b1, v);
    #1;
    waited = 0;
    rdy = v.id ? r1_req_ready : r0_req_ready;
    while (!rdy && waited < 8) begin
      @(negedge clk); #1;
      rdy = v.id ? r1_req_ready : r0_req_ready;
      waited++;
    end
    chk({tag, " ready"}, 32'(rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(v.id, 1'b0, v);
    #1;
    chk({tag, " mem_wr_en"}, 32'(mem_wr_en), 32'(v.we && !v.exp_err));
    chk({tag, " mem_rd_en"}, 32'(mem_rd_en), 32'(!v.we && !v.exp_err));
    @(negedge clk); #1;
    chk({tag, " rsp_valid"}, 32'(v.id ? r1_rsp_valid : r0_rsp_valid), 32'd1);
    chk({tag, " rdata"}, v.id ? r1_rsp_rdata : r0_rsp_rdata, v.exp_rdata);
    chk({tag, " err"}, 32'(v.id ? r1_rsp_err : r0_rsp_err), 32'(v.exp_err));
    chk({tag, " other rsp_valid"}, 32'(v.id ? r0_rsp_valid : r1_rsp_valid), 32'd0);
  endtask

  vec_t vt[15];
  vec_t hv;
  int   gid[4];
  int   gcyc[4];
  int   ng;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    mem[16]   = 32'hDEAD_BEEF;
    mem[33]   = 32'h55AA_55AA;
    mem[1023] = 32'h1234_5678;

    vt[0]  = mk(1'b0, 1'b0, 32'h43,   32'h0,         MASK_B,  32'hFFFF_FFDE, 1'b0);
    vt[1]  = mk(1'b0, 1'b0, 32'h43,   32'h0,         MASK_BU, 32'h0000_00DE, 1'b0);
    vt[2]  = mk(1'b1, 1'b0, 32'h42,   32'h0,         MASK_H,  32'hFFFF_DEAD, 1'b0);
    vt[3]  = mk(1'b1, 1'b0, 32'h40,   32'h0,         MASK_HU, 32'h0000_BEEF, 1'b0);
    vt[4]  = mk(1'b0, 1'b0, 32'h40,   32'h0,         MASK_W,  32'hDEAD_BEEF, 1'b0);
    vt[5]  = mk(1'b1, 1'b1, 32'h06,   32'h7777_7777, MASK_W,  32'h0,         1'b1);
    vt[6]  = mk(1'b0, 1'b0, 32'h1000, 32'h0,         MASK_W,  32'h0,         1'b1);
    vt[7]  = mk(1'b0, 1'b0, 32'hFFC,  32'h0,         MASK_W,  32'h1234_5678, 1'b0);
    vt[8]  = mk(1'b1, 1'b1, 32'h80,   32'hCAFE_F00D, MASK_W,  32'h0,         1'b0);
    vt[9]  = mk(1'b1, 1'b0, 32'h80,   32'h0,         MASK_W,  32'hCAFE_F00D, 1'b0);
    vt[10] = mk(1'b0, 1'b0, 32'h41,   32'h0,         MASK_H,  32'h0,         1'b1);
    vt[11] = mk(1'b0, 1'b0, 32'h40,   32'h0,         3'b011,  32'h0,         1'b1);
    vt[12] = mk(1'b0, 1'b1, 32'h40,   32'h0000_0011, MASK_BU, 32'h0,         1'b1);
    vt[13] = mk(1'b1, 1'b1, 32'h82,   32'h0000_BEEF, MASK_H,  32'h0,         1'b0);
    vt[14] = mk(1'b1, 1'b0, 32'h80,   32'h0,         MASK_W,  32'hBEEF_F00D, 1'b0);

    rst = 1'b1;
    r0_req_valid = 1'b1; r0_req_addr = 32'h40; r0_req_wdata = 32'h0; r0_req_mask = MASK_W; r0_req_we = 1'b1;
    r1_req_valid = 1'b1; r1_req_addr = 32'h80; r1_req_wdata = 32'h0; r1_req_mask = MASK_W; r1_req_we = 1'b0;

    // Everything quiet while reset is held, even with requests pending.
    repeat (3) @(negedge clk);
    #1;
    chk("rst r0_req_ready", 32'(r0_req_ready), 32'd0);
    chk("rst r1_req_ready", 32'(r1_req_ready), 32'd0);
    chk("rst r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
    chk("rst mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst state", 32'(dut.state_r), 32'(ST_IDLE));
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    r0_req_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Tie from reset: r0 first, then alternating at 2-cycle spacing.
    @(negedge clk);
    r0_req_valid = 1'b1; r1_req_valid = 1'b1;
    ng = 0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      #1;
      if (r0_req_ready && r1_req_ready) chk("tie both ready", 32'd1, 32'd0);
      if (r0_req_ready) begin gid[ng] = 0; gcyc[ng] = c; ng++; end
      else if (r1_req_ready) begin gid[ng] = 1; gcyc[ng] = c; ng++; end
      @(negedge clk);
    end
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    chk("tie grant count", 32'(ng), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < ng) begin
        chk("tie grant id", 32'(gid[k]), 32'(k % 2));
        if (k > 0) chk("tie grant spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd2);
      end
    end
    repeat (3) @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // Back-to-back: r0 SB accepted in the RESP cycle of an r1 load.
    @(negedge clk);
    drive(1'b1, 1'b1, mk(1'b1, 1'b0, 32'h40, 32'h0, MASK_W, 32'h0, 1'b0));
    #1;
    chk("b2b r1 ready", 32'(r1_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    r1_req_valid = 1'b0;
    drive(1'b0, 1'b1, mk(1'b0, 1'b1, 32'h1, 32'h0000_00AB, MASK_B, 32'h0, 1'b0));
    #1;
    chk("b2b r0 ready in ACCESS", 32'(r0_req_ready), 32'd0);
    @(negedge clk); #1;
    chk("b2b r0 ready in RESP", 32'(r0_req_ready), 32'd1);
    chk("b2b r1 rsp_valid", 32'(r1_rsp_valid), 32'd1);
    chk("b2b r1 rdata", r1_rsp_rdata, 32'hDEAD_BEEF);
    @(posedge clk);
    @(negedge clk);
    r0_req_valid = 1'b0;
    #1;
    chk("b2b mem_wr_en", 32'(mem_wr_en), 32'd1);
    chk("b2b mem_mask", 32'(mem_mask), 32'd0);
    chk("b2b mem_addr", mem_addr, 32'h1);
    chk("b2b mem_wdata byte", 32'(mem_wdata[7:0]), 32'hAB);
    @(negedge clk); #1;
    chk("b2b r0 rsp_valid", 32'(r0_rsp_valid), 32'd1);
    chk("b2b r0 err", 32'(r0_rsp_err), 32'd0);
    chk("b2b r0 rdata", r0_rsp_rdata, 32'd0);
    chk("b2b mem word0", mem[0], 32'h0000_AB00);
    hv = mk(1'b0, 1'b0, 32'h1, 32'h0, MASK_BU, 32'h0000_00AB, 1'b0);
    run_vec("b2b readback", hv);

    // Reset arrives in the ACCESS cycle of a store: no write, no response.
    @(negedge clk);
    drive(1'b0, 1'b1, mk(1'b0, 1'b1, 32'h84, 32'h1111_2222, MASK_W, 32'h0, 1'b0));
    #1;
    chk("rstwr ready", 32'(r0_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    r0_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstwr mem_wr_en", 32'(mem_wr_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstwr state", 32'(dut.state_r), 32'(ST_IDLE));
    for (int c = 0; c < 3; c++) begin
      chk("rstwr r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
      chk("rstwr r1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
      @(negedge clk); #1;
    end
    chk("rstwr word", mem[33], 32'h55AA_55AA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
